grf_wb_commit: RTL and testbench
================================

// Module: grf_wb_commit
// PURPOSE
//  Write-side front end of the general register file: the only driver of the GRF write port (WE3/A3/WD3/PC).
//  Merges two producers: the in-order pipeline WB stage (never stalls) and the multi-cycle mul/div unit (valid/ready).
//  Holds a small FIFO of mul/div results and a 32-bit pending scoreboard that decode queries to stall RAW/WAW hazards.
// PARAMETERS
//  DEPTH      4   mul/div result FIFO entries (power of 2, >=2)
//  XLEN       32  data / PC width
// PORTS
//  clk            in   1     clock; all state updates on posedge
//  reset          in   1     asynchronous, active-high; clears all state immediately
//  pipe_we        in   1     WB stage write request this cycle (no backpressure)
//  pipe_addr      in   5     WB destination register
//  pipe_data      in   XLEN  WB write data
//  pipe_pc        in   XLEN  PC of WB instruction
//  md_alloc       in   1     mul/div op issued; mark md_alloc_addr pending
//  md_alloc_addr  in   5     destination of issued mul/div op
//  md_valid       in   1     mul/div result offered
//  md_ready       out  1     FIFO can accept result (= !full)
//  md_addr        in   5     result destination
//  md_data        in   XLEN  result data
//  md_pc          in   XLEN  PC of mul/div instruction
//  rs_addr        in   5     decode source-register query 1
//  rt_addr        in   5     decode source-register query 2
//  rs_pending     out  1     pending[rs_addr] (combinational; 0 for reg 0)
//  rt_pending     out  1     pending[rt_addr] (combinational; 0 for reg 0)
//  grf_we         out  1     to GRF WE3 (registered)
//  grf_a3         out  5     to GRF A3 (registered)
//  grf_wd         out  XLEN  to GRF WD3 (registered)
//  grf_pc         out  XLEN  to GRF PC (registered)
// BEHAVIOUR
//  - Reset (async): grf_we/grf_a3/grf_wd/grf_pc = 0; FIFO empty (md_ready=1); pending = 0. In-flight results discarded.
//  - Commit select, each posedge, one write max:
//    1) pipe_we && pipe_addr!=0 -> load output regs from pipe_*, grf_we=1; FIFO not popped.
//    2) else FIFO non-empty -> pop head into output regs, grf_we=1.
//    3) else grf_we=0; grf_a3/grf_wd/grf_pc hold previous values.
//  - pipe_we with pipe_addr==0 is a no-op (does not block FIFO drain).
//  - Latency: pipe write -> grf_we high the cycle after request (1 cycle).
//    md result accepted at edge t -> earliest grf_we at cycle after edge t+1 (2 cycles); FIFO has no bypass.
//  - Handshake: push when md_valid && md_ready at posedge. md_ready depends only on occupancy (no same-cycle pop credit).
//    Producer holds md_* stable while md_valid && !md_ready. md_addr==0 results are accepted and dropped (not pushed).
//  - Scoreboard: pending[a] set at posedge on md_alloc (a=md_alloc_addr!=0);
//    cleared at the posedge a FIFO entry with addr a is loaded into the output regs
//    (GRF internal bypass makes value visible that cycle). Set and clear of same reg on same edge -> set wins.
//  - Ordering: commit order = FIFO order for mul/div; decode stalls on pending, so pipe never writes a pending reg;
//    bench asserts pipe_we && pending[pipe_addr] never occurs.
//  - Starvation: FIFO drains only in cycles without a valid pipe write; acceptable, pipeline bubbles guarantee progress.
//  - Pointers: log2(DEPTH)-bit rd/wr pointers wrap; count 0..DEPTH distinguishes full/empty.
// STRUCTURE
//  - Shared package: REG_AW=5, XLEN default, wb_entry_t {addr[4:0], data, pc}, REG_ZERO=5'd0.
//  - Sub-module: grf_wb_fifo (DEPTH-entry wb_entry_t FIFO, push/pop/full/empty/head, async reset).
//  - Top: commit-select mux + output regs, pending[31:0] register, query muxes.
// TESTING
//  - Reset: assert reset mid-queue (2 entries) -> outputs 0, md_ready=1, pending=0 immediately, no later commit.
//  - Pipe only: pipe_we=1, addr=5, data=32'h1234 -> next cycle grf_we=1, a3=5, wd=32'h1234; addr=0 -> grf_we=0.
//  - Mul/div path: md_alloc addr=8; rs_addr=8 -> rs_pending=1; push data=32'hCAFE, no pipe traffic ->
//    grf_we=1, a3=8 two cycles later, rs_pending=0 that cycle.
//  - Priority: FIFO holds reg 9 while pipe writes reg 3 for 3 cycles -> 3 commits to reg 3, then reg 9.
//  - Full: push DEPTH=4 results with pipe_we=1 every cycle -> md_ready=0 after 4th; 5th held; drains in order once pipe idle.
//  - Set/clear collision: md_alloc reg 8 on same edge reg 8 entry commits -> pending[8] stays 1.

Source files
------------

// File: rtl/grf_wb_commit_pkg.sv
// ============================================================================
// Module : grf_wb_commit_pkg
// Brief  : Shared widths, register-zero constant and write-back entry type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package grf_wb_commit_pkg;

    localparam int              REG_AW   = 5;
    localparam int              XLEN_DEF = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0]   addr;
        logic [XLEN_DEF-1:0] data;
        logic [XLEN_DEF-1:0] pc;
    } wb_entry_t;

    function automatic logic is_real_reg(input logic [REG_AW-1:0] a);
        return a != REG_ZERO;
    endfunction

endpackage

`default_nettype wire

// File: rtl/grf_wb_commit_if.sv
// ============================================================================
// Module : grf_wb_commit_if
// Brief  : Producer/decode/GRF-side signal bundle of the write-back commit unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface grf_wb_commit_if
    import grf_wb_commit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) ();

    logic              pipe_we;
    logic [REG_AW-1:0] pipe_addr;
    logic [XLEN-1:0]   pipe_data;
    logic [XLEN-1:0]   pipe_pc;

    logic              md_alloc;
    logic [REG_AW-1:0] md_alloc_addr;
    logic              md_valid;
    logic              md_ready;
    logic [REG_AW-1:0] md_addr;
    logic [XLEN-1:0]   md_data;
    logic [XLEN-1:0]   md_pc;

    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic              rs_pending;
    logic              rt_pending;

    logic              grf_we;
    logic [REG_AW-1:0] grf_a3;
    logic [XLEN-1:0]   grf_wd;
    logic [XLEN-1:0]   grf_pc;

    modport master (
        output pipe_we, pipe_addr, pipe_data, pipe_pc,
        output md_alloc, md_alloc_addr, md_valid, md_addr, md_data, md_pc,
        output rs_addr, rt_addr,
        input  md_ready, rs_pending, rt_pending,
        input  grf_we, grf_a3, grf_wd, grf_pc
    );

    modport slave (
        input  pipe_we, pipe_addr, pipe_data, pipe_pc,
        input  md_alloc, md_alloc_addr, md_valid, md_addr, md_data, md_pc,
        input  rs_addr, rt_addr,
        output md_ready, rs_pending, rt_pending,
        output grf_we, grf_a3, grf_wd, grf_pc
    );

endinterface

`default_nettype wire

// File: rtl/grf_wb_commit_fifo.sv
// ============================================================================
// Module : grf_wb_fifo
// Brief  : DEPTH-entry FIFO of mul/div write-back entries, no bypass.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module grf_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_din,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_head,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + PW'(1);
            if (w_pop_ok)  r_rd <= r_rd + PW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr] <= i_din;
    end

endmodule

`default_nettype wire

// File: rtl/grf_wb_commit.sv
// ============================================================================
// Module : grf_wb_commit
// Brief  : Sole GRF write-port driver merging WB-stage and mul/div results,
//          with a pending-register scoreboard for decode hazard stalls.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module grf_wb_commit
    import grf_wb_commit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEF
) (
    input  wire logic     clk,
    input  wire logic     reset,
    grf_wb_commit_if.slave bus
);

    localparam int EW = REG_AW + 2 * XLEN;

    logic [EW-1:0]     w_din;
    logic [EW-1:0]     w_head;
    logic [REG_AW-1:0] w_head_addr;
    logic [XLEN-1:0]   w_head_data;
    logic [XLEN-1:0]   w_head_pc;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_pipe_commit;
    logic [31:0]       w_pending_nxt;

    logic              r_we;
    logic [REG_AW-1:0] r_a3;
    logic [XLEN-1:0]   r_wd;
    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_pending;

    assign w_din       = {bus.md_addr, bus.md_data, bus.md_pc};
    assign w_head_addr = w_head[EW-1 -: REG_AW];
    assign w_head_data = w_head[2*XLEN-1 -: XLEN];
    assign w_head_pc   = w_head[XLEN-1:0];

    // Pipe writes win; results to r0 are accepted but never queued.
    assign w_pipe_commit = bus.pipe_we && is_real_reg(bus.pipe_addr);
    assign w_pop         = !w_pipe_commit && !w_empty;
    assign w_push        = bus.md_valid && !w_full && is_real_reg(bus.md_addr);

    grf_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Clear first, then set, so a same-edge alloc of the committing reg wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) w_pending_nxt[w_head_addr] = 1'b0;
        if (bus.md_alloc && is_real_reg(bus.md_alloc_addr))
            w_pending_nxt[bus.md_alloc_addr] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we      <= 1'b0;
            r_a3      <= '0;
            r_wd      <= '0;
            r_pc      <= '0;
            r_pending <= '0;
        end else begin
            if (w_pipe_commit) begin
                r_we <= 1'b1;
                r_a3 <= bus.pipe_addr;
                r_wd <= bus.pipe_data;
                r_pc <= bus.pipe_pc;
            end else if (w_pop) begin
                r_we <= 1'b1;
                r_a3 <= w_head_addr;
                r_wd <= w_head_data;
                r_pc <= w_head_pc;
            end else begin
                r_we <= 1'b0;
            end
            r_pending <= w_pending_nxt;
        end
    end

    assign bus.md_ready   = !w_full;
    assign bus.rs_pending = is_real_reg(bus.rs_addr) && r_pending[bus.rs_addr];
    assign bus.rt_pending = is_real_reg(bus.rt_addr) && r_pending[bus.rt_addr];
    assign bus.grf_we     = r_we;
    assign bus.grf_a3     = r_a3;
    assign bus.grf_wd     = r_wd;
    assign bus.grf_pc     = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_grf_wb_commit.sv
// ============================================================================
// Module : tb_grf_wb_commit
// Brief  : Directed self-checking bench for grf_wb_commit against a queue model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_grf_wb_commit;
    import grf_wb_commit_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    grf_wb_commit_if #(.XLEN(32)) bus ();

    grf_wb_commit #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an ordered queue of accepted results and a set of pending regs.
    wb_entry_t   m_q[$];
    bit [31:0]   m_pend = '0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_a3   = '0;
    logic [31:0] m_wd   = '0;
    logic [31:0] m_pc   = '0;

    initial begin
        forever begin : m_step
            bit        room;
            wb_entry_t e;
            @(posedge clk or posedge reset);
            if (reset) begin
                m_q.delete();
                m_pend = '0;
                m_we = 1'b0; m_a3 = '0; m_wd = '0; m_pc = '0;
            end else begin
                check("pipe_writes_pending_reg",
                      64'(bus.pipe_we && bus.pipe_addr != 0 && m_pend[bus.pipe_addr]), 64'd0);
                room = m_q.size() < DEPTH;
                if (bus.pipe_we && bus.pipe_addr != 0) begin
                    m_we = 1'b1; m_a3 = bus.pipe_addr; m_wd = bus.pipe_data; m_pc = bus.pipe_pc;
                end else if (m_q.size() != 0) begin
                    e = m_q.pop_front();
                    m_we = 1'b1; m_a3 = e.addr; m_wd = e.data; m_pc = e.pc;
                    m_pend[e.addr] = 1'b0;
                end else begin
                    m_we = 1'b0;
                end
                if (bus.md_valid && room && bus.md_addr != 0)
                    m_q.push_back('{addr: bus.md_addr, data: bus.md_data, pc: bus.md_pc});
                if (bus.md_alloc && bus.md_alloc_addr != 0)
                    m_pend[bus.md_alloc_addr] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("grf_we",     64'(bus.grf_we),     64'(m_we));
        check("grf_a3",     64'(bus.grf_a3),     64'(m_a3));
        check("grf_wd",     64'(bus.grf_wd),     64'(m_wd));
        check("grf_pc",     64'(bus.grf_pc),     64'(m_pc));
        check("md_ready",   64'(bus.md_ready),   64'(m_q.size() < DEPTH));
        check("rs_pending", 64'(bus.rs_pending), 64'(bus.rs_addr != 0 && m_pend[bus.rs_addr]));
        check("rt_pending", 64'(bus.rt_pending), 64'(bus.rt_addr != 0 && m_pend[bus.rt_addr]));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic md_offer(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        bus.md_valid = 1'b1; bus.md_addr = a; bus.md_data = d; bus.md_pc = p;
    endtask

    initial begin
        bus.pipe_we = 0; bus.pipe_addr = 0; bus.pipe_data = 0; bus.pipe_pc = 0;
        bus.md_alloc = 0; bus.md_alloc_addr = 0;
        bus.md_valid = 0; bus.md_addr = 0; bus.md_data = 0; bus.md_pc = 0;
        bus.rs_addr = 5'd8; bus.rt_addr = 5'd9;

        // Reset state
        tick(); tick();
        check("rst_we", 64'(bus.grf_we), 64'd0);
        check("rst_ready", 64'(bus.md_ready), 64'd1);
        check("rst_rs_pending", 64'(bus.rs_pending), 64'd0);
        reset = 1'b0;

        // Pipe-only writes, then r0 no-op
        bus.pipe_we = 1; bus.pipe_addr = 5'd5; bus.pipe_data = 32'h1234; bus.pipe_pc = 32'h100;
        tick();
        check("pipe_we", 64'(bus.grf_we), 64'd1);
        check("pipe_a3", 64'(bus.grf_a3), 64'd5);
        check("pipe_wd", 64'(bus.grf_wd), 64'h1234);
        bus.pipe_addr = 5'd0;
        tick();
        check("pipe_r0_we", 64'(bus.grf_we), 64'd0);
        check("pipe_r0_hold_a3", 64'(bus.grf_a3), 64'd5);
        bus.pipe_we = 0;

        // Mul/div path: two-cycle latency and scoreboard clear
        bus.md_alloc = 1; bus.md_alloc_addr = 5'd8;
        tick();
        bus.md_alloc = 0;
        check("md_rs_pending_set", 64'(bus.rs_pending), 64'd1);
        md_offer(5'd8, 32'hCAFE, 32'h200);
        tick();
        bus.md_valid = 0;
        check("md_no_bypass", 64'(bus.grf_we), 64'd0);
        tick();
        check("md_we", 64'(bus.grf_we), 64'd1);
        check("md_a3", 64'(bus.grf_a3), 64'd8);
        check("md_wd", 64'(bus.grf_wd), 64'hCAFE);
        check("md_rs_pending_clr", 64'(bus.rs_pending), 64'd0);

        // Priority: pipe traffic starves the FIFO until it goes idle
        bus.md_alloc = 1; bus.md_alloc_addr = 5'd9;
        md_offer(5'd9, 32'h9999, 32'h300);
        tick();
        bus.md_alloc = 0; bus.md_valid = 0;
        check("prio_rt_pending", 64'(bus.rt_pending), 64'd1);
        bus.pipe_we = 1; bus.pipe_addr = 5'd3; bus.pipe_data = 32'h33; bus.pipe_pc = 32'h400;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("prio_pipe_a3", 64'(bus.grf_a3), 64'd3);
        end
        bus.pipe_we = 0;
        tick();
        check("prio_md_a3", 64'(bus.grf_a3), 64'd9);
        check("prio_md_wd", 64'(bus.grf_wd), 64'h9999);
        check("prio_rt_clr", 64'(bus.rt_pending), 64'd0);

        // Full FIFO with pipe busy, held fifth result, in-order drain
        bus.pipe_we = 1; bus.pipe_addr = 5'd1; bus.pipe_data = 32'h11; bus.pipe_pc = 32'h500;
        for (int i = 0; i < 4; i++) begin
            bus.md_alloc = 1; bus.md_alloc_addr = 5'(10 + i);
            md_offer(5'(10 + i), 32'hA0 + 32'(i), 32'h600 + 32'(i));
            tick();
        end
        check("full_ready_low", 64'(bus.md_ready), 64'd0);
        bus.md_alloc = 1; bus.md_alloc_addr = 5'd14;
        md_offer(5'd14, 32'hA4, 32'h604);
        tick();
        bus.md_alloc = 0;
        check("full_held_ready", 64'(bus.md_ready), 64'd0);
        check("full_pipe_a3", 64'(bus.grf_a3), 64'd1);
        tick();
        check("full_held_ready2", 64'(bus.md_ready), 64'd0);
        bus.pipe_we = 0;
        tick();
        check("drain_a3_10", 64'(bus.grf_a3), 64'd10);
        check("drain_ready", 64'(bus.md_ready), 64'd1);
        tick();
        bus.md_valid = 0;
        check("drain_a3_11", 64'(bus.grf_a3), 64'd11);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("drain_a3", 64'(bus.grf_a3), 64'(12 + j));
            check("drain_wd", 64'(bus.grf_wd), 64'(32'hA2 + 32'(j)));
        end
        tick();
        check("drain_idle", 64'(bus.grf_we), 64'd0);

        // Set/clear collision on reg 8: set wins
        bus.md_alloc = 1; bus.md_alloc_addr = 5'd8;
        md_offer(5'd8, 32'hBEEF, 32'h700);
        tick();
        bus.md_valid = 0;
        tick();
        bus.md_alloc = 0;
        check("coll_a3", 64'(bus.grf_a3), 64'd8);
        check("coll_wd", 64'(bus.grf_wd), 64'hBEEF);
        check("coll_pending_kept", 64'(bus.rs_pending), 64'd1);
        md_offer(5'd8, 32'hF00D, 32'h704);
        tick();
        bus.md_valid = 0;
        tick();
        check("coll_second_wd", 64'(bus.grf_wd), 64'hF00D);
        check("coll_pending_clr", 64'(bus.rs_pending), 64'd0);

        // r0 result accepted but dropped
        md_offer(5'd0, 32'hDEAD, 32'h800);
        tick();
        bus.md_valid = 0;
        tick();
        check("md_r0_dropped", 64'(bus.grf_we), 64'd0);

        // Async reset with two entries queued
        bus.pipe_we = 1; bus.pipe_addr = 5'd2; bus.pipe_data = 32'h22; bus.pipe_pc = 32'h900;
        bus.rs_addr = 5'd20;
        for (int i = 0; i < 2; i++) begin
            bus.md_alloc = 1; bus.md_alloc_addr = 5'(20 + i);
            md_offer(5'(20 + i), 32'hB0 + 32'(i), 32'hA00 + 32'(i));
            tick();
        end
        bus.md_alloc = 0; bus.md_valid = 0;
        check("pre_rst_rs_pending", 64'(bus.rs_pending), 64'd1);
        reset = 1'b1;
        #1;
        check("arst_we", 64'(bus.grf_we), 64'd0);
        check("arst_a3", 64'(bus.grf_a3), 64'd0);
        check("arst_wd", 64'(bus.grf_wd), 64'd0);
        check("arst_pc", 64'(bus.grf_pc), 64'd0);
        check("arst_ready", 64'(bus.md_ready), 64'd1);
        check("arst_rs_pending", 64'(bus.rs_pending), 64'd0);
        bus.pipe_we = 0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_commit", 64'(bus.grf_we), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
